// File: rtl/paillier_collect_pkg.sv
// paillier_collect_pkg: shared FSM state type and round-robin pick for the result collector
package paillier_collect_pkg;

   localparam int MAX_BLOCKS = 64;

   typedef enum logic [1:0] {IDLE, ARB, READ, DONE} state_t;

   // First set bit of elig at or after ptr, wrapping at n; returns ptr when none is set
   function automatic int rr_pick(input logic [MAX_BLOCKS-1:0] elig, input int n, input int ptr);
      int idx;
      int pick;
      pick = ptr;
      for (int j = MAX_BLOCKS - 1; j >= 0; j--) begin
         if (j < n) begin
            idx = ptr + j;
            if (idx >= n) idx = idx - n;
            if (elig[idx]) pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/paillier_result_collector_if.sv
// paillier_result_collector_if: valid/ready result word stream toward the write path
interface paillier_result_collector_if #(parameter int K = 128, parameter int BW = 5);
   logic [K-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [BW-1:0] out_block_id;
   modport master(output out_data, out_valid, out_last, out_block_id, input out_ready);
   modport slave(input out_data, out_valid, out_last, out_block_id, output out_ready);
endinterface

// File: rtl/result_skid_buf.sv
// result_skid_buf: 2-entry fall-through valid/ready buffer; an empty buffer passes input straight out
module result_skid_buf #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic wp, rp, empty, store, pop_mem;
   assign empty     = count == 2'd0;
   assign out_valid = in_valid || !empty;
   assign out_data  = !empty ? mem[rp] : in_valid ? in_data : '0;
   assign pop_mem   = !empty && out_ready;
   assign store     = in_valid && !(empty && out_ready);
   // Upstream throttles reads so count never exceeds 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (store) begin
            mem[wp] <= in_data;
            wp      <= ~wp;
         end
         if (pop_mem) rp <= ~rp;
         count <= count + {1'b0, store} - {1'b0, pop_mem};
      end
   end
endmodule

// File: rtl/paillier_result_collector.sv
// paillier_result_collector: round-robin drain of per-core result FIFOs into one word stream
module paillier_result_collector
   import paillier_collect_pkg::*;
#(
   parameter int BLOCK_COUNT = 29,
   parameter int K = 128,
   parameter int N = 32,
   localparam int CW = $clog2(N) + 1,
   localparam int BW = BLOCK_COUNT > 1 ? $clog2(BLOCK_COUNT) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [31:0]               total_results,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               results_done,
   output logic [BLOCK_COUNT-1:0]    rd_en,
   input  logic [BLOCK_COUNT*K-1:0]  rd_data,
   input  logic [BLOCK_COUNT*CW-1:0] rd_cnt,
   paillier_result_collector_if.master res
);
   state_t state;
   logic [BW-1:0] grant, rr_ptr;
   logic [31:0] total;
   logic [CW-1:0] issued;
   logic inflight, inflight_last, can_read, last_hs;
   logic [1:0] skid_count;
   logic [MAX_BLOCKS-1:0] elig;
   logic [K+BW:0] skid_out;
   always_comb begin
      elig = '0;
      for (int i = 0; i < BLOCK_COUNT; i++) elig[i] = rd_cnt[i*CW +: CW] >= CW'(N);
   end
   // Stored plus in-flight words never exceed the two skid entries
   assign can_read = state == READ && issued != CW'(N) && ({1'b0, skid_count} + {2'b0, inflight}) < 3'd2;
   always_comb begin
      rd_en = '0;
      if (can_read) rd_en[grant] = 1'b1;
   end
   assign last_hs = res.out_valid && res.out_ready && res.out_last;
   result_skid_buf #(.W(K + BW + 1)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (inflight),
      .in_data  ({rd_data[grant*K +: K], grant, inflight_last}),
      .out_valid(res.out_valid),
      .out_ready(res.out_ready),
      .out_data (skid_out),
      .count    (skid_count)
   );
   assign res.out_data     = skid_out[K+BW:BW+1];
   assign res.out_block_id = skid_out[BW:1];
   assign res.out_last     = skid_out[0];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         rr_ptr        <= '0;
         total         <= '0;
         results_done  <= '0;
         issued        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         inflight      <= can_read;
         inflight_last <= can_read && issued == CW'(N - 1);
         if (can_read) issued <= issued + 1'b1;
         case (state)
            IDLE: if (start) begin
               total        <= total_results;
               results_done <= '0;
               done         <= total_results == 32'd0;
               busy         <= total_results != 32'd0;
               state        <= total_results == 32'd0 ? DONE : ARB;
            end
            ARB: if (|elig) begin
               grant  <= BW'(rr_pick(elig, BLOCK_COUNT, int'(rr_ptr)));
               issued <= '0;
               state  <= READ;
            end
            READ: if (last_hs) begin
               results_done <= results_done + 32'd1;
               rr_ptr       <= grant == BW'(BLOCK_COUNT - 1) ? '0 : grant + 1'b1;
               if (results_done + 32'd1 == total) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= ARB;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/paillier_result_collector.md
Name: paillier_result_collector

Overview:
Downstream drain stage for the per-core result FIFOs that follow the BLOCK_COUNT Paillier cores. It arbitrates round-robin among the FIFOs that hold at least one complete N-word result. It streams that result out as N consecutive K-bit words on a valid/ready interface toward the AXI-FULL write path. It counts delivered results against a programmed total and flags completion.

Parameters:
BLOCK_COUNT, 29, number of cores/FIFOs drained
K, 128, word width in bits
N, 32, words per result; also the FIFO depth
CW, $clog2(N)+1, width of each FIFO occupancy count (derived; do not override)
BW, (BLOCK_COUNT>1 ? $clog2(BLOCK_COUNT) : 1), block-id width (derived)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches total_results and begins a job
total_results  in  32  number of complete results to collect for this job
busy  out  1  job in progress
done  out  1  high from job completion until the next accepted start
results_done  out  32  results fully delivered in the current job
rd_en  out  BLOCK_COUNT  per-FIFO read strobe, one word per asserted cycle
rd_data  in  BLOCK_COUNT*K  per-FIFO read data, slice i = [i*K +: K], valid the cycle after rd_en[i]
rd_cnt  in  BLOCK_COUNT*CW  per-FIFO occupancy in words, slice i = [i*CW +: CW]
out_data  out  K  result word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_last  out  1  marks word N-1 of a result
out_block_id  out  BW  source FIFO index of the current word

Behaviour:
- Reset: all outputs 0; FSM in IDLE; rr_ptr=0; results_done=0; skid buffer empty.
- FSM states:
  - IDLE: wait for start. On start, latch total_results and clear results_done/done. If total_results==0, go to DONE next cycle. Otherwise go to ARB with busy=1.
  - ARB: one cycle. Eligible block i means rd_cnt[i] >= N. Choose the first eligible block scanning from rr_ptr upward, modulo BLOCK_COUNT. Latch it as grant and go to READ. If none is eligible, stay in ARB.
  - READ: assert rd_en[grant] for exactly N cycles total, not necessarily consecutive. A read is issued only if (skid_count + inflight) < 2; inflight is 1 in the cycle after a read. Returned data enters a 2-entry skid FIFO that drives out_*. word_cnt counts accepted output beats. out_last=1 when word_cnt==N-1. On the out_last handshake: results_done++, rr_ptr=grant+1 (wrapping at BLOCK_COUNT). Then go to DONE if results_done+1==total_results, else ARB.
  - DONE: busy=0, done=1. Return to IDLE in the same cycle. done holds until the next start.
- Only one rd_en bit is ever high in a cycle; no reads occur outside READ.
- Latency: ARB in cycle t, first rd_en at t+1, first out_valid at t+2. With out_ready held high, one word per cycle and N+2 cycles per result, ARB included.
- Output stability: out_data, out_last and out_block_id stay constant while out_valid && !out_ready. Words are never dropped or duplicated.
- start while busy is ignored.
- A FIFO whose rd_cnt changes during READ does not affect the grant. Words beyond N stay in the FIFO.
- results_done is 32-bit and does not wrap within a job, because the total is bounded by total_results.
- Asynchronous reset mid-transfer aborts immediately and returns everything to reset values. Partial data is discarded; FIFO contents are the upstream owner's concern.

Decomposition:
- Shared package paillier_collect_pkg: the FSM state enum (IDLE, ARB, READ, DONE) and a function rr_pick(eligible vector, rr_ptr) returning the grant index.
- One natural sub-module: result_skid_buf, a 2-entry valid/ready buffer with K+BW+1 bits of payload and count output. Everything else lives in the top FSM.

Test Plan:
- Basic drain: BLOCK_COUNT=4, N=4. Preload FIFO 2 with words 0x10..0x13, total_results=1, out_ready=1. Required: 4 beats 0x10..0x13, out_last on 0x13, out_block_id=2, then done=1 and results_done=1.
- Round-robin fairness: FIFOs 0, 1 and 3 each hold one result, total=3. Required block order 0,1,3; repeating with rr_ptr starting at 2 gives order 3,0,1.
- Backpressure: toggle out_ready 1,0,0,1,0,1... Required: data stable during stalls, all 4 words in order, rd_en never issued while skid_count+inflight=2.
- Zero total: start with total_results=0. Required: done=1 within 2 cycles, no rd_en ever asserted.
- Partial FIFO: FIFO 1 has rd_cnt=N-1, total=1. Required: FSM stays in ARB with no rd_en; raising the count to N starts the drain.
- Reset mid-stream: assert rst_n=0 after word 2 of 4. Required: out_valid, rd_en, busy and done are 0 immediately, and results_done=0.
